sipo_rx: RTL and testbench

Serial-in, parallel-out receiver that is the far end of the team's parallel-load, LSB-first serial shifter. It samples a serial line on a shared bit strobe and assembles WIDTH-bit words. It presents each completed word through a valid/ready handshake to downstream logic. It sits on the receive side of the on-chip serial link, driven by the same clk, bit strobe and frame-sync as the transmitting shifter.

---
 rtl/sipo_rx.sv | 121 ++++++++++++
 tb/tb_sipo_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// LSB-first serial-in/parallel-out receiver with valid/ready word handoff.
// Optional even-parity bit per frame enabled by defining SIPO_RX_PARITY_EN.
module sipo_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  input  logic             sin,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SIPO_RX_PARITY_EN
  localparam int SLO = 0;
`else
  // Without parity the bit shifted out of position 0 is never needed.
  localparam int SLO = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:SLO] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, r_overrun;
  logic             w_sample, w_last_data, w_done;
  logic [WIDTH-1:0] w_shift, w_word;
`ifdef SIPO_RX_PARITY_EN
  logic             r_perr, w_perr;
`endif

  always_comb begin
    w_next      = r_state;
    w_shift     = {sin, r_shreg[WIDTH-1:1]};
    w_sample    = enable && !start;
    w_last_data = (r_state == S_SHIFT) && w_sample && (r_cnt == LAST);
    if (start) begin
      w_next = S_SHIFT;
    end else begin
      case (r_state)
`ifdef SIPO_RX_PARITY_EN
        S_SHIFT:  if (w_last_data) w_next = S_PARITY;
`else
        S_SHIFT:  if (w_last_data) w_next = S_IDLE;
`endif
        S_PARITY: if (w_sample) w_next = S_IDLE;
        default:  w_next = r_state;
      endcase
    end
`ifdef SIPO_RX_PARITY_EN
    w_done = (r_state == S_PARITY) && w_sample;
    w_word = r_shreg;
    w_perr = ^{r_shreg, sin};
`else
    w_done = w_last_data;
    w_word = w_shift;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      if (start) begin
        r_cnt   <= '0;
        r_shreg <= '0;
      end else if (r_state == S_SHIFT && enable) begin
        r_shreg <= w_shift[WIDTH-1:SLO];
        r_cnt   <= w_last_data ? '0 : r_cnt + CW'(1);
      end
      if (r_valid && data_ready) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
        r_perr    <= 1'b0;
`endif
      end
      // A completing word wins over a same-edge acceptance.
      if (w_done) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
        r_perr  <= w_perr;
`endif
        if (r_valid && !data_ready) r_overrun <= 1'b1;
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_valid;
  assign busy       = (r_state != S_IDLE);
  assign overrun    = r_overrun;
`ifdef SIPO_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: vector table, directed corner sequences,
// and random traffic against a frame-level reference model.
module tb_sipo_rx;

  localparam int W = 8;
`ifdef SIPO_RX_PARITY_EN
  localparam int NB  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0, start = 1'b0, enable = 1'b0, sin = 1'b0, data_ready = 1'b0;
  logic [W-1:0] data;
  logic         data_valid, busy, overrun, parity_err;

  sipo_rx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .sin(sin),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is "active" after start and collects bits in a queue.
  bit         m_active;
  bit         m_bits[$];
  logic [W-1:0] m_data;
  bit         m_valid, m_ovr, m_perr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit st, input bit en, input bit s, input bit rdy);
    bit acc, done, par;
    logic [W-1:0] word;
    done = 1'b0; par = 1'b0; word = '0;
    if (r) begin
      m_active = 0; m_bits.delete(); m_data = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
    end else begin
      acc = m_valid && rdy;
      if (st) begin
        m_active = 1; m_bits.delete();
      end else if (m_active && en) begin
        m_bits.push_back(s);
        if (m_bits.size() == NB) begin
          done = 1; m_active = 0;
          for (int i = 0; i < NB; i++) begin
            if (i < W) word[i] = m_bits[i];
            par ^= m_bits[i];
          end
        end
      end
      if (done && m_valid && !rdy) m_ovr = 1;
      else if (acc)                m_ovr = 0;
      if (done) begin
        m_data = word; m_valid = 1; m_perr = PAR && par;
      end else if (acc) begin
        m_valid = 0; m_perr = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit st, input bit en, input bit s, input bit rdy);
    rst = r; start = st; enable = en; sin = s; data_ready = rdy;
    @(posedge clk);
    model_edge(r, st, en, s, rdy);
    #1;
    check("data", data, m_data);
    check("data_valid", data_valid, m_valid);
    check("busy", busy, m_active);
    check("overrun", overrun, m_ovr);
    check("parity_err", parity_err, m_perr);
  endtask

  // Frame with random gaps; last_rdy is the ready level on the final strobe.
  task automatic send_frame(input logic [W-1:0] word, input bit rdy, input bit last_rdy,
                            input int maxgap, input bit pbit_flip);
    bit b;
    step(0, 1, 0, 0, rdy);
    for (int k = 0; k < NB; k++) begin
      repeat ($urandom_range(maxgap, 0)) step(0, 0, 0, 1'($urandom), rdy);
      b = (k < W) ? word[k] : ((^word) ^ pbit_flip);
      step(0, 0, 1, b, (k == NB - 1) ? last_rdy : rdy);
    end
  endtask

  typedef struct {
    bit r, st, en, s, rdy;
    logic [W-1:0] d;
    bit v, b, o;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit st, input bit en, input bit s, input bit rdy,
                              input logic [W-1:0] d, input bit v, input bit b, input bit o);
    vec_t x;
    x.r = r; x.st = st; x.en = en; x.s = s; x.rdy = rdy; x.d = d; x.v = v; x.b = b; x.o = o;
    return x;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [W-1:0] a5;
    bit done;
    a5 = 8'hA5;

    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 1, 0));
    for (int k = 0; k < W; k++) begin
      done = (k == W - 1) && (NB == W);
      tbl.push_back(mk(0, 0, 1, a5[k], 0, done ? a5 : 8'h00, done, !done, 0));
    end
`ifdef SIPO_RX_PARITY_EN
    tbl.push_back(mk(0, 0, 1, 0, 0, a5, 1, 0, 0));
`endif
    tbl.push_back(mk(0, 0, 0, 0, 1, a5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, a5, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].st, tbl[i].en, tbl[i].s, tbl[i].rdy);
      check($sformatf("tbl%0d_data", i), data, tbl[i].d);
      check($sformatf("tbl%0d_valid", i), data_valid, tbl[i].v);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
      check($sformatf("tbl%0d_ovr", i), overrun, tbl[i].o);
    end

    // Non-contiguous strobes
    send_frame(8'h3C, 0, 0, 3, 0);
    check("noncontig_data", data, 8'h3C);
    check("noncontig_valid", data_valid, 1);
    check("noncontig_busy_after", busy, 0);
    step(0, 0, 0, 0, 1);

    // Overrun and its clearing by acceptance
    send_frame(8'h11, 0, 0, 0, 0);
    send_frame(8'h22, 0, 0, 1, 0);
    check("ovr_data", data, 8'h22);
    check("ovr_valid", data_valid, 1);
    check("ovr_flag", overrun, 1);
    step(0, 0, 0, 0, 1);
    check("ovr_clr_valid", data_valid, 0);
    check("ovr_clr_flag", overrun, 0);

    // Completion on the same edge as acceptance
    send_frame(8'h5A, 0, 0, 0, 0);
    send_frame(8'h99, 0, 1, 2, 0);
    check("same_edge_data", data, 8'h99);
    check("same_edge_valid", data_valid, 1);
    check("same_edge_ovr", overrun, 0);
    step(0, 0, 0, 0, 1);

    // Abort by start, with start beating a concurrent enable
    step(0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    check("abort_valid", data_valid, 0);
    check("abort_busy", busy, 1);
    for (int k = 0; k < NB; k++) step(0, 0, 1, (k < W) ? (k >= 4) : 1'b0, 0);
    check("abort_data", data, 8'hF0);
    check("abort_valid_new", data_valid, 1);

    // Reset mid-frame with a pending word
    step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);

`ifdef SIPO_RX_PARITY_EN
    send_frame(8'hA5, 0, 0, 0, 1);
    check("par_bad_err", parity_err, 1);
    check("par_bad_valid", data_valid, 1);
    step(0, 0, 0, 0, 1);
    check("par_clr", parity_err, 0);
    send_frame(8'hA5, 0, 0, 0, 0);
    check("par_good_err", parity_err, 0);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(199, 0) == 0), ($urandom_range(19, 0) == 0),
           1'($urandom), 1'($urandom), ($urandom_range(3, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
